// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle sequencer.
package ctrl_pkg;

  // Default bound on cycles a memory request may wait for its ack.
  localparam int unsigned TIMEOUT_DEFAULT = 32'd16;

  // Sequencer states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_HALT   = ST_HALT;

  // Instruction class captured in DECODE; at most one of load/store/branch is set.
  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic writes_reg;
  } iclass_t;

  // Resolve the decoder flags with load > store > branch > ALU priority.
  function automatic iclass_t decode_class(input logic is_load, input logic is_store,
                                           input logic is_branch, input logic writes_reg);
    iclass_t c;
    c.load       = is_load;
    c.store      = is_store & ~is_load;
    c.branch     = is_branch & ~is_load & ~is_store;
    c.writes_reg = writes_reg;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake, decode-class and strobe bundle between the sequencer and the datapath.
interface multicycle_ctrl_if;
  logic        imem_ack;
  logic        dmem_ack;
  logic        is_halt;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        writes_reg;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        dmem_we;
  logic        pc_load;
  logic        pc_sel;
  logic        rf_wren;
  logic        halted;
  logic        err;
  logic [31:0] retired;
  logic [2:0]  state;

  // Sequencer side.
  modport master (
    input  imem_ack, dmem_ack, is_halt, is_load, is_store, is_branch,
           writes_reg, branch_taken,
    output imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_sel,
           rf_wren, halted, err, retired, state
  );

  // Datapath / memory side.
  modport slave (
    output imem_ack, dmem_ack, is_halt, is_load, is_store, is_branch,
           writes_reg, branch_taken,
    input  imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_sel,
           rf_wren, halted, err, retired, state
  );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Bounded wait counter for memory handshakes. expired fires combinationally in
// the TIMEOUT-th waiting cycle when that cycle also has no ack.
module wait_timer #(
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic clk,
  input  logic rstd,
  input  logic clear,
  input  logic tick,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 32'd1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 32'd0) ? CW'(TIMEOUT - 32'd1) : '0;
  localparam logic ENABLED = (TIMEOUT != 32'd0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count waiting cycles; the count saturates at the last allowed cycle.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !ack) begin
      if (cnt_q == LAST) begin
        expired = ENABLED;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with bounded
// memory waits and a retired-instruction counter. Strobes are decoded from the
// registered state plus current-cycle acks, and are forced to their idle values
// while rstd is low so pending requests drop immediately.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                clk,
  input logic                rstd,
  multicycle_ctrl_if.master  bus
);

  logic [2:0]  state_q, state_d;
  iclass_t     cls_q, cls_d;
  logic        err_q, err_d;
  logic [31:0] retired_q, retired_d;

  logic imem_req_s, ir_load_s, dmem_req_s, dmem_we_s;
  logic pc_load_s, pc_sel_s, rf_wren_s, halted_s;
  logic in_wait_s, ack_s, expired_s;

  // Waiting states and the ack relevant to the current one.
  assign in_wait_s = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack_s     = (state_q == S_FETCH) ? bus.imem_ack :
                     (state_q == S_MEM)   ? bus.dmem_ack : 1'b0;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rstd    (rstd),
    .clear   (!in_wait_s || ack_s),
    .tick    (in_wait_s),
    .ack     (ack_s),
    .expired (expired_s)
  );

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    err_d      = err_q;
    imem_req_s = 1'b0;
    ir_load_s  = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    pc_load_s  = 1'b0;
    pc_sel_s   = 1'b0;
    rf_wren_s  = 1'b1;
    halted_s   = 1'b0;
    if (rstd) begin
      case (state_q)
        S_FETCH: begin
          imem_req_s = 1'b1;
          if (bus.imem_ack) begin
            ir_load_s = 1'b1;
            state_d   = S_DECODE;
          end else if (expired_s) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          cls_d = decode_class(bus.is_load, bus.is_store, bus.is_branch, bus.writes_reg);
          if (bus.is_halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls_q.load || cls_q.store) begin
            state_d = S_MEM;
          end else if (cls_q.branch) begin
            pc_load_s = 1'b1;
            pc_sel_s  = bus.branch_taken;
            state_d   = S_FETCH;
          end else if (cls_q.writes_reg) begin
            state_d = S_WB;
          end else begin
            pc_load_s = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_MEM: begin
          dmem_req_s = 1'b1;
          dmem_we_s  = cls_q.store;
          if (bus.dmem_ack) begin
            if (cls_q.load) begin
              state_d = S_WB;
            end else begin
              pc_load_s = 1'b1;
              state_d   = S_FETCH;
            end
          end else if (expired_s) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_MEM;
          end
        end
        S_WB: begin
          rf_wren_s = 1'b0;
          pc_load_s = 1'b1;
          state_d   = S_FETCH;
        end
        S_HALT: begin
          halted_s = 1'b1;
          state_d  = S_HALT;
        end
        default: begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      endcase
    end else begin
      state_d = S_FETCH;
    end
  end

  // One retirement per PC update; wraps naturally at 2^32.
  always_comb begin
    retired_d = retired_q + {31'd0, pc_load_s};
  end

  // State, class, error and retirement registers.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_q   <= S_FETCH;
      cls_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign bus.imem_req = imem_req_s;
  assign bus.ir_load  = ir_load_s;
  assign bus.dmem_req = dmem_req_s;
  assign bus.dmem_we  = dmem_we_s;
  assign bus.pc_load  = pc_load_s;
  assign bus.pc_sel   = pc_sel_s;
  assign bus.rf_wren  = rf_wren_s;
  assign bus.halted   = halted_s;
  assign bus.err      = err_q;
  assign bus.retired  = retired_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the expected
// outputs for that cycle; a monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;

  logic clk;
  logic rstd;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: {imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_sel, rf_wren, halted, err}
  localparam logic [8:0] F_IDLE = 9'b000000100;
  localparam logic [8:0] F_FREQ = 9'b100000100;
  localparam logic [8:0] F_FACK = 9'b110000100;
  localparam logic [8:0] F_MLD  = 9'b001000100;
  localparam logic [8:0] F_MST  = 9'b001100100;
  localparam logic [8:0] F_MSTA = 9'b001110100;
  localparam logic [8:0] F_WB   = 9'b000010000;
  localparam logic [8:0] F_PC   = 9'b000010100;
  localparam logic [8:0] F_BR   = 9'b000011100;
  localparam logic [8:0] F_HLT  = 9'b000000110;
  localparam logic [8:0] F_ERR  = 9'b000000111;
  localparam logic [8:0] F_RERR = 9'b000000101;

  // Decode inputs: {is_halt, is_load, is_store, is_branch, writes_reg}
  localparam logic [4:0] D_NO   = 5'b00000;
  localparam logic [4:0] D_ALUW = 5'b00001;
  localparam logic [4:0] D_BR   = 5'b00010;
  localparam logic [4:0] D_ST   = 5'b00100;
  localparam logic [4:0] D_LD   = 5'b01000;
  localparam logic [4:0] D_HL   = 5'b11000;

  typedef struct {
    string       lbl;
    logic [2:0]  st;
    logic [8:0]  fl;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Drive one cycle of inputs, record what the DUT must show in it, advance.
  task automatic cyc(input string lbl, input logic r, input logic ia, input logic da,
                     input logic [4:0] dec, input logic tk,
                     input logic [2:0] st, input logic [8:0] fl, input logic [31:0] ret);
    exp_t e;
    rstd             = r;
    bus.imem_ack     = ia;
    bus.dmem_ack     = da;
    bus.is_halt      = dec[4];
    bus.is_load      = dec[3];
    bus.is_store     = dec[2];
    bus.is_branch    = dec[1];
    bus.writes_reg   = dec[0];
    bus.branch_taken = tk;
    e.lbl = lbl;
    e.st  = st;
    e.fl  = fl;
    e.ret = ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare mid-cycle against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] fl_a;
      e = exp_q.pop_front();
      fl_a = {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.pc_load,
              bus.pc_sel, bus.rf_wren, bus.halted, bus.err};
      tests_run++;
      if (bus.state !== e.st || fl_a !== e.fl || bus.retired !== e.ret) begin
        tests_failed++;
        $display("FAIL %s: got state=%0d flags=%b retired=%0d, expected state=%0d flags=%b retired=%0d",
                 e.lbl, bus.state, fl_a, bus.retired, e.st, e.fl, e.ret);
      end
    end
  end

  initial begin
    rstd = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    bus.is_halt = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0;
    bus.is_branch = 1'b0; bus.writes_reg = 1'b0; bus.branch_taken = 1'b0;
    @(posedge clk);
    #1;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) cyc("reset", 1'b0, 1'b0, 1'b0, D_NO, 1'b0, 3'd0, F_IDLE, 32'd0);

    // ALU op with register write, immediate ack: F,D,E,WB.
    cyc("aluw_f",  1'b1, 1'b1, 1'b0, D_NO,   1'b0, 3'd0, F_FACK, 32'd0);
    cyc("aluw_d",  1'b1, 1'b0, 1'b0, D_ALUW, 1'b0, 3'd1, F_IDLE, 32'd0);
    cyc("aluw_e",  1'b1, 1'b0, 1'b0, D_NO,   1'b0, 3'd2, F_IDLE, 32'd0);
    cyc("aluw_wb", 1'b1, 1'b0, 1'b0, D_NO,   1'b0, 3'd4, F_WB,   32'd0);

    // Load with dmem_ack delayed 3 cycles (ack lands in the last allowed cycle).
    cyc("ld_f",  1'b1, 1'b1, 1'b0, D_NO, 1'b0, 3'd1 - 3'd1, F_FACK, 32'd1);
    cyc("ld_d",  1'b1, 1'b0, 1'b1, D_LD, 1'b0, 3'd1, F_IDLE, 32'd1);
    cyc("ld_e",  1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd2, F_IDLE, 32'd1);
    for (int i = 0; i < 3; i++) cyc("ld_mwait", 1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd3, F_MLD, 32'd1);
    cyc("ld_mack", 1'b1, 1'b0, 1'b1, D_NO, 1'b0, 3'd3, F_MLD, 32'd1);
    cyc("ld_wb",   1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd4, F_WB,  32'd1);

    // Store with immediate ack, then taken branch.
    cyc("st_f",  1'b1, 1'b1, 1'b0, D_NO, 1'b0, 3'd0, F_FACK, 32'd2);
    cyc("st_d",  1'b1, 1'b0, 1'b0, D_ST, 1'b0, 3'd1, F_IDLE, 32'd2);
    cyc("st_e",  1'b1, 1'b0, 1'b1, D_NO, 1'b0, 3'd2, F_IDLE, 32'd2);
    cyc("st_m",  1'b1, 1'b0, 1'b1, D_NO, 1'b0, 3'd3, F_MSTA, 32'd2);
    cyc("br_f",  1'b1, 1'b1, 1'b0, D_NO, 1'b0, 3'd0, F_FACK, 32'd3);
    cyc("br_d",  1'b1, 1'b0, 1'b0, D_BR, 1'b0, 3'd1, F_IDLE, 32'd3);
    cyc("br_e",  1'b1, 1'b0, 1'b0, D_NO, 1'b1, 3'd2, F_BR,   32'd3);

    // ALU op without register write: 3 cycles.
    cyc("alu_f", 1'b1, 1'b1, 1'b0, D_NO, 1'b0, 3'd0, F_FACK, 32'd4);
    cyc("alu_d", 1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd1, F_IDLE, 32'd4);
    cyc("alu_e", 1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd2, F_PC,   32'd4);

    // Halt together with load: HALT after DECODE, acks ignored while halted.
    cyc("hl_f",  1'b1, 1'b1, 1'b0, D_NO, 1'b0, 3'd0, F_FACK, 32'd5);
    cyc("hl_d",  1'b1, 1'b0, 1'b0, D_HL, 1'b0, 3'd1, F_IDLE, 32'd5);
    for (int i = 0; i < 20; i++) cyc("hl_stay", 1'b1, 1'b1, 1'b1, D_LD, 1'b1, 3'd5, F_HLT, 32'd5);
    cyc("hl_rst", 1'b0, 1'b0, 1'b0, D_NO, 1'b0, 3'd5, F_IDLE, 32'd5);

    // Fetch timeout: imem_req high exactly 4 cycles, then HALT with err.
    for (int i = 0; i < 4; i++) cyc("ito_wait", 1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd0, F_FREQ, 32'd0);
    for (int i = 0; i < 3; i++) cyc("ito_err",  1'b1, 1'b1, 1'b0, D_NO, 1'b0, 3'd5, F_ERR,  32'd0);
    cyc("ito_rst", 1'b0, 1'b0, 1'b0, D_NO, 1'b0, 3'd5, F_RERR, 32'd0);

    // Store data timeout: no pc_load, HALT with err.
    cyc("dto_f", 1'b1, 1'b1, 1'b0, D_NO, 1'b0, 3'd0, F_FACK, 32'd0);
    cyc("dto_d", 1'b1, 1'b0, 1'b0, D_ST, 1'b0, 3'd1, F_IDLE, 32'd0);
    cyc("dto_e", 1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd2, F_IDLE, 32'd0);
    for (int i = 0; i < 4; i++) cyc("dto_wait", 1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd3, F_MST, 32'd0);
    cyc("dto_err", 1'b1, 1'b0, 1'b1, D_NO, 1'b0, 3'd5, F_ERR, 32'd0);
    cyc("dto_rst", 1'b0, 1'b0, 1'b0, D_NO, 1'b0, 3'd5, F_RERR, 32'd0);

    // Retire one instruction, then reset during WB of the next.
    cyc("rw_f1", 1'b1, 1'b1, 1'b0, D_NO,   1'b0, 3'd0, F_FACK, 32'd0);
    cyc("rw_d1", 1'b1, 1'b0, 1'b0, D_NO,   1'b0, 3'd1, F_IDLE, 32'd0);
    cyc("rw_e1", 1'b1, 1'b0, 1'b0, D_NO,   1'b0, 3'd2, F_PC,   32'd0);
    cyc("rw_f2", 1'b1, 1'b1, 1'b0, D_NO,   1'b0, 3'd0, F_FACK, 32'd1);
    cyc("rw_d2", 1'b1, 1'b0, 1'b0, D_ALUW, 1'b0, 3'd1, F_IDLE, 32'd1);
    cyc("rw_e2", 1'b1, 1'b0, 1'b0, D_NO,   1'b0, 3'd2, F_IDLE, 32'd1);
    cyc("rw_wbrst", 1'b0, 1'b0, 1'b0, D_NO, 1'b0, 3'd4, F_IDLE, 32'd1);
    cyc("rw_after", 1'b1, 1'b0, 1'b0, D_NO, 1'b0, 3'd0, F_FREQ, 32'd0);

    // Bounded drain of any expectation the monitor has not consumed.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the RISC core. Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the control strobes:
- PC register load enable
- instruction-register load
- register-file write enable (active-low, matching the register file's `wren`)
- instruction and data memory request handshakes

It sits beside the PC/register-file datapath and replaces single-cycle "every clock" PC update with per-instruction sequencing, a bounded memory wait and a retired-instruction count.

## Interface
- `TIMEOUT`, default 16: maximum cycles a memory request may wait for ack; 0 disables the timeout.
- `clk` in 1: clock; all state changes on rising edge.
- `rstd` in 1: reset; synchronous, active-low.
- `imem_ack` in 1: instruction memory ack; valid only while `imem_req`=1.
- `dmem_ack` in 1: data memory ack; valid only while `dmem_req`=1.
- `is_halt`, `is_load`, `is_store`, `is_branch`, `writes_reg` in 1 each: decoded class of the IR contents; sampled in DECODE.
- `branch_taken` in 1: branch condition from ALU; sampled in EXEC.
- `imem_req` out 1: fetch request.
- `ir_load` out 1: load instruction register.
- `dmem_req` out 1: data request.
- `dmem_we` out 1: data write (store).
- `pc_load` out 1: load PC with next PC.
- `pc_sel` out 1: 1 selects branch target, 0 selects PC+4.
- `rf_wren` out 1: register-file write enable, active-low.
- `halted` out 1: core stopped.
- `err` out 1: stopped due to memory timeout.
- `retired` out 32: count of completed instructions.
- `state` out 3: current state, for debug.

## Operation
- States are FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH**
  - `imem_req`=1.
  - On `imem_ack`: `ir_load`=1 in that cycle, then go to DECODE.
- **DECODE**
  - Latch the class register.
  - Priority is halt > load > store > branch > ALU. `is_load` and `is_store` both set is treated as a load.
  - `is_halt` → HALT; otherwise → EXEC.
- **EXEC**
  - Load or store → MEM.
  - Branch: `pc_load`=1, `pc_sel`=`branch_taken`, → FETCH.
  - ALU with `writes_reg`=1 → WB.
  - ALU with `writes_reg`=0: `pc_load`=1, → FETCH.
- **MEM**
  - `dmem_req`=1; `dmem_we`=1 for a store.
  - On `dmem_ack`: load → WB; store → `pc_load`=1, then FETCH.
- **WB**
  - `rf_wren`=0 for exactly one cycle.
  - `pc_load`=1, `pc_sel`=0, → FETCH.
- **HALT**
  - Absorbing state; `halted`=1; all strobes inactive. Only reset leaves it.
- `pc_load` is asserted exactly once per non-halt instruction. `retired` increments in that same cycle and wraps modulo 2^32.
- **Timeout**
  - A wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - An ack in cycle `TIMEOUT` is still accepted.
  - If there is no ack within `TIMEOUT` cycles: → HALT with `err`=1. No `pc_load`, no `rf_wren`.
- A halt instruction does not increment `retired`.

## Timing
- **Strobe timing**
  - All outputs are decoded from the registered state plus the current-cycle ack/decode inputs.
  - `ir_load`, `pc_load` (MEM store completion) and `dmem_we`/`dmem_req` gating have no extra cycle.
- **Reset values** (while `rstd`=0 at a rising edge): state=FETCH, `retired`=0, `err`=0, wait counter=0. Outputs while reset is held:
  - `imem_req`=0, `ir_load`=0, `dmem_req`=0, `dmem_we`=0, `pc_load`=0, `pc_sel`=0
  - `rf_wren`=1, `halted`=0
- The first `imem_req`=1 appears in the first cycle after `rstd` is seen high.
- **Reset mid-operation**: aborts at the next edge. No `rf_wren` or `pc_load` pulse completes afterwards; pending requests drop the same cycle.
- **Latency with zero-wait ack** (ack in first request cycle):
  - Branch: 3 cycles.
  - ALU without register write: 3 cycles.
  - Store: 4 cycles.
  - ALU with register write: 4 cycles.
  - Load: 5 cycles.
  - Each cycle of wait adds 1.
- **Handshake**: `imem_req`/`dmem_req` stay high until the ack cycle inclusive, then drop the next cycle. An ack while the request is low is ignored.

## Structure
- Shared package `ctrl_pkg` holds:
  - state enum (3-bit encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5)
  - instruction-class struct (load/store/branch/writes_reg)
  - default `TIMEOUT`
- Natural sub-module: `wait_timer`. It takes clear/tick/ack inputs and a `TIMEOUT` parameter, produces an expired output, and sizes its counter as clog2(`TIMEOUT`+1).
- The state register, class register and `retired` counter live in the top module.

## Test plan
- Reset held 3 cycles, then ALU op with `writes_reg`=1 and immediate acks → states F,D,E,WB; `rf_wren`=0 only in cycle 4; `pc_load`=1 in cycle 4; `retired`=1.
- Load with `dmem_ack` delayed 3 cycles → 8 cycles total; `dmem_we`=0; single `rf_wren` pulse; `retired` increments once.
- Store then branch with `branch_taken`=1 → store: `pc_load` on the ack cycle, no `rf_wren`; branch: `pc_sel`=1 at EXEC; `retired`=2.
- `TIMEOUT`=4 and `imem_ack` never asserted → `imem_req` high exactly 4 cycles, then HALT with `err`=1, `halted`=1, `retired` unchanged.
- `is_halt`=1 together with `is_load`=1 → HALT after DECODE; no `dmem_req`; stays halted for 20 cycles; `rstd` low one edge → FETCH, `retired`=0, `err`=0.
- `rstd` asserted during WB → no `rf_wren` pulse on the following edge; outputs at reset values next cycle.
